// File: rtl/axis_demux_mcast.sv
// axis_demux_mcast
// ----------------
// AXI4-Stream frame-level multicast demultiplexer. The select mask and drop
// request are captured on the first beat of each frame. Every beat of the frame
// is then copied to all selected outputs. Each output has a 2-entry skid buffer
// (output register + temp register), so a stalled output only blocks frames
// that are sent to it.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   s_axis_*           input stream (tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser)
//   m_axis_*           M_COUNT output streams, concatenated; port i is slice i
//   enable             0 forces s_axis_tready low (frame state is held)
//   drop               sampled at frame start; 1 discards the whole frame
//   select_mask        sampled at frame start; bit i sends the frame to output i
//   busy               frame in progress (this is the frame FSM state, IN_FRAME)
//   stat_drop          one-cycle registered pulse after the tlast of a dropped frame
//
// Handshake semantics (all ports): a beat transfers on a rising clk edge where
// tvalid && tready are both high. Once m_axis_tvalid[i] is asserted, it and its
// payload stay stable until m_axis_tready[i] is seen high. s_axis_tready is
// combinational from registered state, enable and the effective frame control.

module axis_demux_mcast #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter bit ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [ID_WIDTH-1:0]            s_axis_tid,
  input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,

  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]             m_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_axis_tready,
  output logic [M_COUNT-1:0]             m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]    m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]  m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser,

  input  logic                           enable,
  input  logic                           drop,
  input  logic [M_COUNT-1:0]             select_mask,
  output logic                           busy,
  output logic                           stat_drop
);

  // A beat is carried through the buffers as one packed word.
  localparam int USER_LSB = 0;
  localparam int DEST_LSB = USER_LSB + USER_WIDTH;
  localparam int ID_LSB   = DEST_LSB + DEST_WIDTH;
  localparam int LAST_BIT = ID_LSB + ID_WIDTH;
  localparam int KEEP_LSB = LAST_BIT + 1;
  localparam int DATA_LSB = KEEP_LSB + KEEP_WIDTH;
  localparam int BEAT_W   = DATA_LSB + DATA_WIDTH;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [M_COUNT-1:0]  mask_reg, mask_ctl;
  logic                drop_reg, drop_ctl;
  logic                accept;
  logic [M_COUNT-1:0]  load;
  logic [M_COUNT-1:0]  rdy_reg;
  logic [M_COUNT-1:0]  out_valid, temp_valid;
  logic [BEAT_W-1:0]   out_beat  [M_COUNT];
  logic [BEAT_W-1:0]   temp_beat [M_COUNT];
  logic [BEAT_W-1:0]   beat_in;

  // Disabled sidebands are replaced here so the buffers hold exactly what
  // the outputs must show.
  always_comb begin
    beat_in = '0;
    beat_in[DATA_LSB +: DATA_WIDTH] = s_axis_tdata;
    beat_in[KEEP_LSB +: KEEP_WIDTH] = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
    beat_in[LAST_BIT]               = s_axis_tlast;
    beat_in[ID_LSB +: ID_WIDTH]     = ID_ENABLE ? s_axis_tid : {ID_WIDTH{1'b0}};
    beat_in[DEST_LSB +: DEST_WIDTH] = DEST_ENABLE ? s_axis_tdest : {DEST_WIDTH{1'b0}};
    beat_in[USER_LSB +: USER_WIDTH] = USER_ENABLE ? s_axis_tuser : {USER_WIDTH{1'b0}};
  end

  // Frame FSM next state, effective control and input handshake.
  always_comb begin
    state_next = state;
    mask_ctl   = mask_reg;
    drop_ctl   = drop_reg;
    // At a frame start the live inputs are used; an empty mask is a drop.
    if (state == IDLE) begin
      mask_ctl = select_mask;
      drop_ctl = drop || (select_mask == '0);
    end
    // Unselected outputs are forced ready so they never block the frame.
    s_axis_tready = enable && !rst && (drop_ctl || (&(rdy_reg | ~mask_ctl)));
    accept        = s_axis_tvalid && s_axis_tready;
    load          = {M_COUNT{accept && !drop_ctl}} & mask_ctl;
    case (state)
      IDLE:     if (accept && !s_axis_tlast) state_next = IN_FRAME;
      IN_FRAME: if (accept && s_axis_tlast)  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_reg  <= '0;
      drop_reg  <= 1'b0;
      stat_drop <= 1'b0;
    end else begin
      state     <= state_next;
      stat_drop <= accept && s_axis_tlast && drop_ctl;
      if (state == IDLE && accept) begin
        mask_reg <= mask_ctl;
        drop_reg <= drop_ctl;
      end
    end
  end

  assign busy = (state == IN_FRAME);

  // Per-output skid buffers. rdy_reg is a registered view of "temp empty and
  // output free", so when rdy_reg[i] is high the temp register is known to be
  // empty and an incoming beat always has a place to go. That keeps the input
  // ready free of any combinational path from m_axis_tready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < M_COUNT; i++) begin
      if (rst) begin
        out_valid[i]  <= 1'b0;
        temp_valid[i] <= 1'b0;
        rdy_reg[i]    <= 1'b0;
      end else begin
        rdy_reg[i] <= !temp_valid[i] && (!out_valid[i] || m_axis_tready[i]);
        if (load[i]) begin
          if (!out_valid[i] || m_axis_tready[i]) begin
            out_valid[i] <= 1'b1;
            out_beat[i]  <= beat_in;
          end else begin
            temp_valid[i] <= 1'b1;
            temp_beat[i]  <= beat_in;
          end
        end else if (!out_valid[i] || m_axis_tready[i]) begin
          // Output slot frees up with nothing new arriving: promote temp.
          out_valid[i]  <= temp_valid[i];
          out_beat[i]   <= temp_beat[i];
          temp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tvalid = out_valid;

  for (genvar i = 0; i < M_COUNT; i++) begin : g_out
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = out_beat[i][DATA_LSB +: DATA_WIDTH];
    assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = out_beat[i][KEEP_LSB +: KEEP_WIDTH];
    assign m_axis_tlast[i]                          = out_beat[i][LAST_BIT];
    assign m_axis_tid[i*ID_WIDTH +: ID_WIDTH]       = out_beat[i][ID_LSB +: ID_WIDTH];
    assign m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] = out_beat[i][DEST_LSB +: DEST_WIDTH];
    assign m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] = out_beat[i][USER_LSB +: USER_WIDTH];
  end

endmodule

// File: tb/tb_axis_demux_mcast.sv
// Testbench for axis_demux_mcast (M_COUNT=4, DATA_WIDTH=8, default sidebands).
// A negedge monitor keeps a frame-level reference model: it works out which
// outputs each accepted beat must reach, queues the beat per output and pops
// it when that output hands it over. Directed sequences cover exact timing.

module tb_axis_demux_mcast;
  localparam int M  = 4;
  localparam int DW = 8;
  localparam int EW = DW + 2;  // {tlast, tuser, tdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]   s_axis_tdata;
  logic [0:0]      s_axis_tkeep;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            s_axis_tlast;
  logic [7:0]      s_axis_tid;
  logic [7:0]      s_axis_tdest;
  logic [0:0]      s_axis_tuser;
  logic [M*DW-1:0] m_axis_tdata;
  logic [M-1:0]    m_axis_tkeep;
  logic [M-1:0]    m_axis_tvalid;
  logic [M-1:0]    m_axis_tready;
  logic [M-1:0]    m_axis_tlast;
  logic [M*8-1:0]  m_axis_tid;
  logic [M*8-1:0]  m_axis_tdest;
  logic [M-1:0]    m_axis_tuser;
  logic            enable;
  logic            drop;
  logic [M-1:0]    select_mask;
  logic            busy;
  logic            stat_drop;

  axis_demux_mcast #(.M_COUNT(M), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .enable(enable), .drop(drop), .select_mask(select_mask),
    .busy(busy), .stat_drop(stat_drop)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q [M][$];
  bit            in_frame  = 1'b0;
  bit            cur_drop  = 1'b0;
  logic [M-1:0]  cur_mask  = '0;
  bit            pend_drop = 1'b0;
  bit            prev_rst  = 1'b0;
  bit            eff_drop;
  logic [M-1:0]  eff_mask;
  logic [M-1:0]  prev_valid = '0;
  logic [M-1:0]  prev_ready = '0;
  logic [EW-1:0] prev_beat [M];
  logic [EW-1:0] got_beat;
  logic [EW-1:0] exp_beat;
  int            pop_cnt [M];
  int            drop_pulses = 0;

  initial for (int i = 0; i < M; i++) pop_cnt[i] = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_s_tready", s_axis_tready, 0);
      for (int i = 0; i < M; i++) exp_q[i].delete();
      in_frame   = 1'b0;
      pend_drop  = 1'b0;
      prev_valid = '0;
      prev_rst   = 1'b1;
    end else begin
      if (prev_rst) begin
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_stat_drop", stat_drop, 0);
      end
      prev_rst = 1'b0;
      check("busy", busy, in_frame);
      check("stat_drop", stat_drop, pend_drop);
      if (stat_drop) drop_pulses++;
      pend_drop = 1'b0;

      // output side
      for (int i = 0; i < M; i++) begin
        got_beat = {m_axis_tlast[i], m_axis_tuser[i], m_axis_tdata[i*DW +: DW]};
        if (prev_valid[i] && !prev_ready[i]) begin
          check($sformatf("hold_valid_p%0d", i), m_axis_tvalid[i], 1);
          check($sformatf("hold_beat_p%0d", i), got_beat, prev_beat[i]);
        end
        if (m_axis_tvalid[i] && m_axis_tready[i]) begin
          pop_cnt[i]++;
          check($sformatf("beat_expected_p%0d", i), exp_q[i].size() > 0, 1);
          if (exp_q[i].size() > 0) begin
            exp_beat = exp_q[i].pop_front();
            check($sformatf("beat_p%0d", i), got_beat, exp_beat);
          end
          check("keep_ones", m_axis_tkeep[i], 1);
          check("id_zero", m_axis_tid[i*8 +: 8], 0);
          check("dest_zero", m_axis_tdest[i*8 +: 8], 0);
        end
        prev_beat[i] = got_beat;
      end
      prev_valid = m_axis_tvalid;
      prev_ready = m_axis_tready;

      // input side
      if (in_frame) begin
        eff_mask = cur_mask;
        eff_drop = cur_drop;
      end else begin
        eff_mask = select_mask;
        eff_drop = drop || (select_mask == '0);
      end
      if (!enable) check("tready_disabled", s_axis_tready, 0);
      else if (eff_drop) check("drop_always_ready", s_axis_tready, 1);
      if (s_axis_tvalid && s_axis_tready) begin
        for (int i = 0; i < M; i++)
          if (!eff_drop && eff_mask[i])
            exp_q[i].push_back({s_axis_tlast, s_axis_tuser[0], s_axis_tdata});
        if (s_axis_tlast) begin
          in_frame  = 1'b0;
          pend_drop = eff_drop;
        end else begin
          in_frame = 1'b1;
          cur_mask = eff_mask;
          cur_drop = eff_drop;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_ready = 1'b0;
  bit rand_en    = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = M'($urandom_range(0, (1 << M) - 1));
    if (rand_en) enable = ($urandom_range(0, 7) != 0);
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic l, input logic u,
                       input logic [M-1:0] mk, input logic dr);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tkeep  = 1'($urandom_range(0, 1));
    s_axis_tid    = 8'($urandom_range(0, 255));
    s_axis_tdest  = 8'($urandom_range(0, 255));
    select_mask   = mk;
    drop          = dr;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic u,
                           input logic [M-1:0] mk, input logic dr);
    bit acc;
    int t;
    drive(d, l, u, mk, dr);
    t = 0;
    forever begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      if (acc) break;
      t++;
      if (t > 300) begin
        check("send_timeout", t, 0);
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int c0, c1, c2, c3, d0, len;
  logic [M-1:0] fmask;
  bit fdrop;

  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    s_axis_tkeep = '0; s_axis_tid = '0; s_axis_tdest = '0;
    m_axis_tready = '1; enable = 1'b1; drop = 1'b0; select_mask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_tvalid", m_axis_tvalid, 0);
    settle(3);

    // 1. unicast, exact latency and busy window
    drive(8'hA1, 0, 0, 4'b0001, 0);
    @(negedge clk); check("t1_rdy0", s_axis_tready, 1);
    tick(); drive(8'hA2, 0, 0, 4'b0001, 0);
    @(negedge clk); check("t1_v1", m_axis_tvalid, 4'b0001);
    check("t1_d1", m_axis_tdata[7:0], 8'hA1); check("t1_busy1", busy, 1);
    check("t1_rdy1", s_axis_tready, 1);
    tick(); drive(8'hA3, 1, 0, 4'b0001, 0);
    @(negedge clk); check("t1_v2", m_axis_tvalid, 4'b0001);
    check("t1_d2", m_axis_tdata[7:0], 8'hA2); check("t1_busy2", busy, 1);
    check("t1_rdy2", s_axis_tready, 1);
    tick(); idle();
    @(negedge clk); check("t1_v3", m_axis_tvalid, 4'b0001);
    check("t1_d3", m_axis_tdata[7:0], 8'hA3); check("t1_last3", m_axis_tlast[0], 1);
    check("t1_busy3", busy, 0);
    tick();
    @(negedge clk); check("t1_v4", m_axis_tvalid, 0);
    settle(2);

    // 2. multicast to ports 0 and 2, port 2 stalled
    m_axis_tready = 4'b1011;
    c0 = pop_cnt[0];
    drive(8'hB1, 0, 1, 4'b0101, 0);
    @(negedge clk); check("t2_rdy0", s_axis_tready, 1);
    tick(); drive(8'hB2, 0, 0, 4'b0101, 0);
    @(negedge clk); check("t2_rdy1", s_axis_tready, 1);
    tick(); drive(8'hB3, 0, 1, 4'b0101, 0);
    repeat (4) begin
      @(negedge clk); check("t2_stall", s_axis_tready, 0);
      check("t2_p2_valid", m_axis_tvalid[2], 1);
      tick();
    end
    check("t2_p0_count", pop_cnt[0] - c0, 2);
    m_axis_tready = 4'b1111;
    send_beat(8'hB3, 0, 1, 4'b0101, 0);
    send_beat(8'hB4, 1, 0, 4'b0101, 0);
    idle(); settle(6);

    // 3. dropped frames with every output stalled
    m_axis_tready = 4'b0000;
    d0 = drop_pulses;
    for (int b = 0; b < 5; b++) begin
      if (b < 3) drive(8'hC0 + 8'(b), b == 2, 0, 4'b0000, 0);
      else drive(8'hD0 + 8'(b), b == 4, 1, 4'b1111, 1);
      @(negedge clk); check("t3_rdy", s_axis_tready, 1);
      check("t3_no_valid", m_axis_tvalid, 0);
      tick();
    end
    idle(); settle(3);
    check("t3_drop_pulses", drop_pulses - d0, 2);
    m_axis_tready = 4'b1111;
    settle(2);

    // 4. mid-frame select/drop changes are ignored
    c1 = pop_cnt[1]; c3 = pop_cnt[3];
    send_beat(8'h41, 0, 0, 4'b0010, 0);
    send_beat(8'h42, 0, 1, 4'b1000, 1);
    send_beat(8'h43, 1, 0, 4'b1000, 0);
    idle(); settle(4);
    check("t4_p1_count", pop_cnt[1] - c1, 3);
    check("t4_p3_count", pop_cnt[3] - c3, 0);

    // 5. back-to-back single-beat frames
    drive(8'h11, 1, 0, 4'b0001, 0);
    @(negedge clk); check("t5_rdy0", s_axis_tready, 1);
    tick(); drive(8'h22, 1, 1, 4'b1110, 0);
    @(negedge clk); check("t5_no_bubble", s_axis_tready, 1);
    check("t5_v0", m_axis_tvalid, 4'b0001); check("t5_d0", m_axis_tdata[7:0], 8'h11);
    tick(); idle();
    @(negedge clk); check("t5_v1", m_axis_tvalid, 4'b1110);
    check("t5_d1", m_axis_tdata[15:8], 8'h22); check("t5_d2", m_axis_tdata[23:16], 8'h22);
    check("t5_d3", m_axis_tdata[31:24], 8'h22);
    settle(3);

    // 6. reset in the middle of a buffered frame
    m_axis_tready = 4'b0000;
    send_beat(8'h61, 0, 0, 4'b0001, 0);
    send_beat(8'h62, 0, 0, 4'b0001, 0);
    drive(8'h63, 0, 0, 4'b0001, 0);
    rst = 1'b1;
    @(negedge clk); check("t6_rst_rdy", s_axis_tready, 0);
    tick(); rst = 1'b0;
    @(negedge clk); check("t6_tvalid", m_axis_tvalid, 0); check("t6_busy", busy, 0);
    tick();
    m_axis_tready = 4'b1111;
    c0 = pop_cnt[0]; c2 = pop_cnt[2];
    send_beat(8'h5C, 1, 1, 4'b0100, 0);
    idle(); settle(4);
    check("t6_p2_count", pop_cnt[2] - c2, 1);
    check("t6_p0_count", pop_cnt[0] - c0, 0);

    // randomized frames, random backpressure and enable
    rand_ready = 1'b1; rand_en = 1'b1;
    for (int f = 0; f < 150; f++) begin
      len   = $urandom_range(1, 5);
      fmask = M'($urandom_range(0, (1 << M) - 1));
      fdrop = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < len; b++) begin
        if (b == 0) send_beat(8'($urandom_range(0, 255)), len == 1, 1'($urandom_range(0, 1)), fmask, fdrop);
        else send_beat(8'($urandom_range(0, 255)), b == len - 1, 1'($urandom_range(0, 1)),
                       M'($urandom_range(0, (1 << M) - 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          idle(); tick();
        end
      end
      idle();
    end
    rand_ready = 1'b0; rand_en = 1'b0;
    enable = 1'b1; m_axis_tready = 4'b1111;
    settle(20);
    for (int i = 0; i < M; i++) check($sformatf("drain_empty_p%0d", i), exp_q[i].size(), 0);
    check("drain_tvalid", m_axis_tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_demux_mcast.md
Name: axis_demux_mcast

Overview:
AXI4-Stream frame-level multicast demultiplexer with per-output elastic buffering. A one-hot or multi-hot select mask is captured at the first beat of each frame. Every beat of that frame is replicated to all selected outputs. Each output has its own 2-entry skid buffer, so a slow output stalls only frames that target it. The block sits after the packet classifier, alongside the unicast demux, for flood/mirror traffic.

Parameters:
M_COUNT, 4, number of output streams (1..32)
DATA_WIDTH, 8, tdata width
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; if 0, outputs drive all-ones
KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width
ID_ENABLE, 0, propagate tid; if 0, outputs drive zero
ID_WIDTH, 8, tid width
DEST_ENABLE, 0, propagate tdest; if 0, outputs drive zero
DEST_WIDTH, 8, tdest width
USER_ENABLE, 1, propagate tuser; if 0, outputs drive zero
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  DATA_WIDTH/KEEP_WIDTH/1/1/1/ID_WIDTH/DEST_WIDTH/USER_WIDTH  input stream
m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  M_COUNT x each width  concatenated output streams; port i occupies slice i
enable  in  1  when 0, s_axis_tready forced 0
drop  in  1  sampled at frame start; 1 discards the whole frame
select_mask  in  M_COUNT  sampled at frame start; bit i sends the frame to output i
busy  out  1  frame in progress (registered frame state)
stat_drop  out  1  one-cycle pulse, registered, on tlast acceptance of a dropped frame

Behaviour:
- Reset values: all m_axis_tvalid=0, skid temp valids=0, internal ready regs=0, s_axis_tready=0, busy=0, stat_drop=0, frame state idle. A reset mid-frame discards any buffered beats. The next accepted beat is treated as a frame start.
- Frame state: IDLE -> IN_FRAME on accepting a non-tlast beat. IN_FRAME -> IDLE on accepting a tlast beat. A single-beat frame (first beat has tlast) stays in IDLE.
- Effective control:
  - In IDLE, mask_ctl = select_mask and drop_ctl = drop | (select_mask==0), both taken combinationally.
  - In IN_FRAME, both use the values latched at frame start.
  - Changes to drop or select_mask mid-frame are ignored.
- Per-output ready: rdy_reg[i] is registered as !temp_valid[i] && (!m_tvalid[i] || m_tready[i]).
- Input handshake: s_axis_tready = enable && (drop_ctl || &(rdy_reg | ~mask_ctl)). All selected outputs must have space; unselected outputs never block.
- Replication: on an accepted, non-dropped beat, each output i with mask_ctl[i]=1 loads the beat:
  - into its output register if that register is empty or is being consumed this cycle;
  - otherwise into its temp register.
  - When an output register is consumed and no new beat is loaded, the temp register moves to the output register.
- Latency: beat accepted in cycle N appears on m_axis_tvalid[i] in cycle N+1. Sustained throughput is 1 beat/cycle when all selected outputs hold tready=1.
- Ordering: per output, beats leave in acceptance order. Frames reaching different outputs may complete at different times.
- Per-output data registers: each output has its own data, keep, last, id, dest and user registers. Sidebands pass unchanged, without tdest stripping.
- Dropped frame:
  - All beats are accepted whenever enable=1, regardless of output readiness.
  - No output tvalid is asserted for the frame.
  - stat_drop pulses in the cycle after its tlast is accepted.
- Simultaneous events: a buffer may consume and load in the same cycle; no beat is lost or duplicated. The last beat of one frame and the first beat of the next may be accepted in consecutive cycles with different masks.
- enable=0 mid-frame: input stalls and frame state is held. Beats already buffered continue to drain.
- AXI rule: once asserted, m_axis_tvalid[i] and its data are held stable until m_axis_tready[i]=1.

Test Plan:
1. Unicast. M_COUNT=4, mask=0001, 3-beat frame 0xA1,0xA2,0xA3 (tlast on 3rd), all tready=1 -> port0 outputs A1..A3 in cycles N+1..N+3 with tlast on A3; ports1-3 tvalid stay 0; busy high for 2 cycles.
2. Multicast with backpressure. mask=0101, 4-beat frame, m_tready[2]=0 -> port0 receives 2 beats; s_axis_tready drops once port2 holds 2 beats. After m_tready[2]=1, both ports receive all 4 beats in order, none duplicated.
3. Drop. Frame with mask=0000 (and a second frame with drop=1, mask=1111), all tready=0 -> s_axis_tready=1 throughout; no m_axis_tvalid; stat_drop pulses once per frame.
4. Mid-frame mask change. Frame started with mask=0010, select_mask switched to 1000 at beat 2 -> all beats appear on port1 only.
5. Back-to-back single-beat frames. Frame 0x11/mask 0001 then frame 0x22/mask 1110 in consecutive cycles, all tready=1 -> port0 gets 0x11; ports1-3 each get 0x22 one cycle later; no stall bubbles.
6. Reset mid-frame. rst for 1 cycle after beat 2 of a 5-beat frame with 1 beat buffered -> all tvalid=0, busy=0, s_axis_tready=0 during reset; the next beat is treated as a new frame start using the current select_mask.
